seg7_readback_decoder: RTL and testbench
========================================

// Module: seg7_readback_decoder
// PURPOSE
//   Receive-side counterpart of the 7-segment display driver: samples the segment bus (uo_out[6:0]),
//   waits for each pattern to settle, decodes it back to a hex nibble and queues it for a consumer.
//   Lets a loopback/self-check path read back what the display shows. Flags undecodable patterns.
// PARAMETERS
//   STABLE_CYCLES  4   consecutive identical samples needed before a pattern is accepted (>=2)
//   DEPTH          4   output FIFO entries (power of 2, >=2)
// PORTS
//   clk         in   1  clock
//   rst         in   1  synchronous reset, active-high
//   ena         in   1  block enable; low = sampler frozen, stability counter held at 0
//   seg_in      in   7  segment bus, bit0=a .. bit6=g, active-high
//   out_valid   out  1  FIFO head valid
//   out_ready   in   1  consumer accepts head when out_valid&&out_ready
//   out_nibble  out  4  decoded hex value of head (0 when out_err)
//   out_err     out  1  head pattern is not a legal hex glyph
//   out_raw     out  7  raw segment pattern of head
//   overflow    out  1  sticky: an accept was dropped because FIFO full; cleared only by rst
//   err_count   out  8  count of accepted illegal patterns (only with SEG7_RB_ERRCNT_EN)
// BEHAVIOUR
//   - Reset (rst=1 at edge): all outputs 0, FIFO flushed, seg_q=0, stab_cnt=0, accepted flag clear.
//     Reset mid-stream discards queued entries; pattern must re-settle fully after rst deasserts.
//   - Sampler: seg_q<=seg_in each cycle while ena. stab_cnt clears when seg_in!=seg_q, else increments,
//     saturating at STABLE_CYCLES. Accept event: single-cycle pulse when stab_cnt reaches STABLE_CYCLES-1
//     and seg_in==seg_q. Exactly one accept per stable period; no repeat while the pattern is held.
//   - Latency: pattern held on seg_in for STABLE_CYCLES consecutive edges -> out_valid high next cycle
//     (if FIFO was empty).
//   - Decode: a=0x3F,1=0x06,2=0x5B,3=0x4F,4=0x66,5=0x6D,6=0x7D,7=0x07,8=0x7F,9=0x6F,A=0x77,b=0x7C,
//     C=0x39,d=0x5E,E=0x79,F=0x71 (entry for 0 is 0x3F). 0x00 (blank) = accepted but never pushed.
//     Any other pattern -> push {err=1,nibble=0,raw}.
//   - FIFO: first-word-fall-through; head stable while out_valid&&!out_ready. Push when full and no pop:
//     entry dropped, overflow<=1. Push and pop same cycle when full: both succeed, count unchanged.
//     Pop when empty: ignored. Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
//   - ena low: no sampling, no accept; FIFO still drains normally.
// CONFIGURATION
//   SEG7_RB_ERRCNT_EN defined: err_count increments on every accepted illegal pattern (including ones
//     dropped by overflow), saturates at 255, cleared by rst.
//   Not defined: err_count tied to 8'd0, no counter flops.
// STRUCTURE
//   seg7_pkg: SEG_BLANK, the 16 glyph constants, function seg_to_hex(seg)->{err,nibble}; shared with
//     the display driver so encode/decode tables cannot diverge.
//   Sub-module seg7_rb_fifo: DEPTH x 12-bit sync FIFO {err,nibble,raw}, FWFT, full/empty.
//   Top: sampler + stability counter + decode + push logic + optional error counter.
// TESTING (STABLE_CYCLES=4, DEPTH=4)
//   seg_in=0x5B held 6 cycles, out_ready=1 -> one entry nibble=2 err=0 raw=0x5B, out_valid 1 cycle.
//   seg_in=0x5B 3 cycles, 0x4F 5 cycles -> only nibble=3 emitted (first pattern never settled).
//   seg_in=0x00 held 10 cycles -> no out_valid; then 0x49 held 5 -> err=1 raw=0x49, err_count=1 (EN).
//   out_ready=0, accept 5 settled glyphs 1,2,3,4,5 -> 4 queued, overflow=1; drain yields 1,2,3,4.
//   FIFO full + new accept with out_ready=1 same cycle -> pop 1 and push succeed, overflow stays 0.
//   rst pulsed with 2 entries queued and 0x06 settling -> out_valid=0 next cycle; 0x06 emitted only
//     after 4 more stable cycles post-reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and decoder, used by both the display driver and the readback path
// so the encode and decode tables cannot drift apart.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;

    typedef struct packed {
        logic             err;
        logic [NIB_W-1:0] nibble;
    } seg7_dec_t;

    // One readback FIFO entry
    typedef struct packed {
        logic             err;
        logic [NIB_W-1:0] nibble;
        logic [SEG_W-1:0] raw;
    } seg7_entry_t;

    // Blank and every non-glyph pattern report err with nibble 0
    function automatic seg7_dec_t seg_to_hex(input logic [SEG_W-1:0] seg);
        seg7_dec_t d;
        d.err    = 1'b0;
        d.nibble = '0;
        case (seg)
            SEG_0:   d.nibble = 4'h0;
            SEG_1:   d.nibble = 4'h1;
            SEG_2:   d.nibble = 4'h2;
            SEG_3:   d.nibble = 4'h3;
            SEG_4:   d.nibble = 4'h4;
            SEG_5:   d.nibble = 4'h5;
            SEG_6:   d.nibble = 4'h6;
            SEG_7:   d.nibble = 4'h7;
            SEG_8:   d.nibble = 4'h8;
            SEG_9:   d.nibble = 4'h9;
            SEG_A:   d.nibble = 4'hA;
            SEG_B:   d.nibble = 4'hB;
            SEG_C:   d.nibble = 4'hC;
            SEG_D:   d.nibble = 4'hD;
            SEG_E:   d.nibble = 4'hE;
            SEG_F:   d.nibble = 4'hF;
            default: d.err    = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_rb_fifo.sv
// First-word-fall-through synchronous FIFO holding decoded readback entries.
module seg7_rb_fifo
    import seg7_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  seg7_entry_t wdata_i,
    output seg7_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    seg7_entry_t    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Samples the 7-segment bus, waits for a settled pattern, decodes it and queues it for a consumer.
// Optional accepted-illegal-pattern counter enabled by defining SEG7_RB_ERRCNT_EN.
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DEPTH         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [SEG_W-1:0] seg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB_W-1:0] out_nibble,
    output logic             out_err,
    output logic [SEG_W-1:0] out_raw,
    output logic             overflow,
    output logic [7:0]       err_count
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ACC = SW'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] seg_q, seg_d;
    logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
    logic             accepted_q, accepted_d;
    logic             overflow_q, overflow_d;
    logic             accept_c;
    logic             push_c;
    logic             illegal_c;
    logic             fifo_full;
    logic             fifo_empty;
    seg7_dec_t        dec_c;
    seg7_entry_t      wentry_c;
    seg7_entry_t      head;

    // Sampler and stability counter; accepted flag blocks a repeat accept after an ena gap
    always_comb begin
        seg_d      = seg_q;
        stab_cnt_d = stab_cnt_q;
        accepted_d = accepted_q;
        accept_c   = 1'b0;
        if (ena) begin
            seg_d = seg_in;
            if (seg_in != seg_q) begin
                stab_cnt_d = '0;
                accepted_d = 1'b0;
            end else begin
                if (stab_cnt_q != STAB_MAX) begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
                if (stab_cnt_q == STAB_ACC && !accepted_q) begin
                    accept_c   = 1'b1;
                    accepted_d = 1'b1;
                end
            end
        end else begin
            stab_cnt_d = '0;
        end
    end

    always_comb begin
        dec_c           = seg_to_hex(seg_q);
        push_c          = accept_c && (seg_q != SEG_BLANK);
        illegal_c       = push_c && dec_c.err;
        wentry_c.err    = dec_c.err;
        wentry_c.nibble = dec_c.nibble;
        wentry_c.raw    = seg_q;
        overflow_d      = overflow_q || (push_c && fifo_full && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            stab_cnt_q <= '0;
            accepted_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            stab_cnt_q <= stab_cnt_d;
            accepted_q <= accepted_d;
            overflow_q <= overflow_d;
        end
    end

    seg7_rb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (out_ready),
        .wdata_i (wentry_c),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_err    = head.err;
    assign out_nibble = head.nibble;
    assign out_raw    = head.raw;
    assign overflow   = overflow_q;

`ifdef SEG7_RB_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Counts illegal accepts even when the FIFO drops them
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (illegal_c && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_c;
    assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder (STABLE_CYCLES=4, DEPTH=4).
module tb_seg7_readback_decoder;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [6:0] seg_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_err;
    logic [6:0] out_raw;
    logic       overflow;
    logic [7:0] err_count;

    int n_checks;
    int n_errors;
    int valid_cycles;
    logic [11:0] cap[$];

    seg7_readback_decoder #(
        .STABLE_CYCLES (4),
        .DEPTH         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .seg_in     (seg_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_err    (out_err),
        .out_raw    (out_raw),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake as {err,nibble,raw}; inputs are stable around the negedge
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) cap.push_back({out_err, out_nibble, out_raw});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] cap_at(input int i);
        if (i < cap.size()) return cap[i];
        return 12'hFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] seg, input int n);
        seg_in = seg;
        repeat (n) tick();
    endtask

    task automatic clear_log();
        cap.delete();
        valid_cycles = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        valid_cycles = 0;
        rst          = 1'b1;
        ena          = 1'b1;
        seg_in       = 7'h00;
        out_ready    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_raw", 32'(out_raw), 32'd0);
        check("rst_nibble", 32'(out_nibble), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);

        // Single settled glyph with consumer ready
        clear_log();
        hold(7'h5B, 6);
        hold(7'h00, 6);
        check("t1_count", 32'(cap.size()), 32'd1);
        check("t1_entry", 32'(cap_at(0)), 32'({1'b0, 4'h2, 7'h5B}));
        check("t1_vcycles", 32'(valid_cycles), 32'd1);

        // Short pattern never settles
        clear_log();
        hold(7'h5B, 3);
        hold(7'h4F, 5);
        hold(7'h00, 6);
        check("t2_count", 32'(cap.size()), 32'd1);
        check("t2_entry", 32'(cap_at(0)), 32'({1'b0, 4'h3, 7'h4F}));

        // Blank is never pushed; illegal pattern flagged
        clear_log();
        hold(7'h00, 10);
        check("t3_blank_vcycles", 32'(valid_cycles), 32'd0);
        hold(7'h49, 5);
        hold(7'h00, 6);
        check("t3_count", 32'(cap.size()), 32'd1);
        check("t3_entry", 32'(cap_at(0)), 32'({1'b1, 4'h0, 7'h49}));
`ifdef SEG7_RB_ERRCNT_EN
        check("t3_errcnt", 32'(err_count), 32'd1);
`else
        check("t3_errcnt", 32'(err_count), 32'd0);
`endif

        // Overflow: five accepts into a four-deep FIFO with no consumer
        clear_log();
        out_ready = 1'b0;
        hold(7'h06, 5);
        hold(7'h5B, 5);
        hold(7'h4F, 5);
        hold(7'h66, 5);
        hold(7'h6D, 5);
        hold(7'h00, 5);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_head", 32'(out_nibble), 32'd1);
        out_ready = 1'b1;
        hold(7'h00, 6);
        check("t4_count", 32'(cap.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_nib%0d", i), 32'(cap_at(i) >> 7), 32'(i + 1));
        end
        check("t4_empty", 32'(out_valid), 32'd0);

        // Full FIFO: push and pop in the same cycle both succeed
        do_reset();
        clear_log();
        out_ready = 1'b0;
        hold(7'h06, 5);
        hold(7'h5B, 5);
        hold(7'h4F, 5);
        hold(7'h66, 5);
        check("t5_full_ovf", 32'(overflow), 32'd0);
        hold(7'h6D, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_head", 32'(out_nibble), 32'd2);
        tick();
        check("t5_no_repeat", 32'(cap.size()), 32'd1);
        out_ready = 1'b1;
        hold(7'h00, 6);
        check("t5_count", 32'(cap.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_nib%0d", i), 32'(cap_at(i) >> 7), 32'(i + 1));
        end

        // Reset mid-stream discards queue and restarts settling
        clear_log();
        out_ready = 1'b0;
        hold(7'h5B, 5);
        hold(7'h4F, 5);
        check("t6_queued", 32'(out_valid), 32'd1);
        hold(7'h06, 2);
        do_reset();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_raw", 32'(out_raw), 32'd0);
        repeat (4) tick();
        check("t6_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_entry", 32'({out_err, out_nibble, out_raw}), 32'({1'b0, 4'h1, 7'h06}));
        check("t6_overflow", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
